// File: rtl/axil_pkg.sv
// Shared constants and types for the AXI-Lite register slave.
// The write-holding record is sized for the widest supported bus.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_IDX   = 0;
  localparam int STATUS_IDX = 1;
  localparam int START_BIT  = 0;

  localparam int HOLD_IDX_W  = 32;
  localparam int HOLD_DATA_W = 64;
  localparam int HOLD_STRB_W = HOLD_DATA_W / 8;

  typedef struct packed {
    logic [HOLD_IDX_W-1:0]  idx;
    logic [HOLD_DATA_W-1:0] data;
    logic [HOLD_STRB_W-1:0] strb;
  } wr_hold_t;

  function automatic logic [HOLD_DATA_W-1:0] strb_merge(
    input logic [HOLD_DATA_W-1:0] old_w,
    input logic [HOLD_DATA_W-1:0] new_w,
    input logic [HOLD_STRB_W-1:0] strb
  );
    logic [HOLD_DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < HOLD_STRB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bundle with master and slave views.
// Address and data widths must match on both ends.
interface AXIL_IF #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport Slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport Master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/axil_wr_capture.sv
// AW/W holding registers and ready generation for a single
// outstanding AXI-Lite write.
module axil_wr_capture
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    bvalid_d,
  input  logic                    b_hs,
  output logic                    both_held,
  output wr_hold_t                hold
);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  logic     aw_held_q, aw_held_d;
  logic     w_held_q, w_held_d;
  logic     awready_q, awready_d;
  logic     wready_q, wready_d;
  wr_hold_t hold_q, hold_d;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    hold_d    = hold_q;
    if (b_hs) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (awvalid && awready_q) begin
      aw_held_d  = 1'b1;
      hold_d.idx = HOLD_IDX_W'(awaddr[ADDR_WIDTH-1:OFF_W]);
    end
    if (wvalid && wready_q) begin
      w_held_d    = 1'b1;
      hold_d.data = HOLD_DATA_W'(wdata);
      hold_d.strb = HOLD_STRB_W'(wstrb);
    end
    // Readies are registered so they stay low through reset.
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      hold_q    <= hold_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign both_held = aw_held_q && w_held_q;
  assign hold      = hold_q;

endmodule

// File: rtl/axil_reg_slave.sv
// AXI-Lite control/status register bank: CTRL with start pulse,
// read-only STATUS, and general config words.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  AXIL_IF.Slave                            s_axil,
  input  logic [DATA_WIDTH-1:0]            status_i,
  output logic [DATA_WIDTH-1:0]            ctrl_o,
  output logic                             start_o,
  output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] regs_o
);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] cfg_q [2:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] cfg_d [2:NUM_REGS-1];
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  start_q, start_d;

  logic                   aw_rdy, w_rdy;
  logic                   both_held, b_hs, wr_fire, wr_err;
  wr_hold_t               hold;
  logic [HOLD_IDX_W-1:0]  wr_idx;
  logic [DATA_WIDTH-1:0]  old_w;
  logic [HOLD_DATA_W-1:0] merged;

  axil_wr_capture #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_capture (
    .clk       (clk),
    .rst       (rst),
    .awaddr    (s_axil.awaddr),
    .awvalid   (s_axil.awvalid),
    .awready   (aw_rdy),
    .wdata     (s_axil.wdata),
    .wstrb     (s_axil.wstrb),
    .wvalid    (s_axil.wvalid),
    .wready    (w_rdy),
    .bvalid_d  (bvalid_d),
    .b_hs      (b_hs),
    .both_held (both_held),
    .hold      (hold)
  );

  assign b_hs    = bvalid_q && s_axil.bready;
  assign wr_fire = both_held && !bvalid_q;
  assign wr_idx  = hold.idx;
  assign wr_err  = (wr_idx >= HOLD_IDX_W'(NUM_REGS))
                || (wr_idx == HOLD_IDX_W'(STATUS_IDX));

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    start_d  = 1'b0;
    ctrl_d   = ctrl_q;
    cfg_d    = cfg_q;
    old_w    = '0;
    if (wr_idx == HOLD_IDX_W'(CTRL_IDX)) old_w = ctrl_q;
    for (int i = 2; i < NUM_REGS; i++) begin
      if (wr_idx == HOLD_IDX_W'(i)) old_w = cfg_q[i];
    end
    merged = strb_merge(HOLD_DATA_W'(old_w), hold.data, hold.strb);
    if (b_hs) bvalid_d = 1'b0;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
      if (!wr_err) begin
        if (wr_idx == HOLD_IDX_W'(CTRL_IDX)) begin
          ctrl_d  = merged[DATA_WIDTH-1:0];
          start_d = hold.strb[START_BIT] && hold.data[START_BIT];
        end
        for (int i = 2; i < NUM_REGS; i++) begin
          if (wr_idx == HOLD_IDX_W'(i)) cfg_d[i] = merged[DATA_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      cfg_q    <= '{default: '0};
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      start_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      cfg_q    <= cfg_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      start_q  <= start_d;
    end
  end

  // Read decode and FSM
  rd_state_t             rd_state_q;
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_val;
  logic [1:0]            rresp_q;
  logic                  rd_err;
  logic [HOLD_IDX_W-1:0] rd_idx;

  assign rd_idx = HOLD_IDX_W'(s_axil.araddr[ADDR_WIDTH-1:OFF_W]);

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    if (rd_idx >= HOLD_IDX_W'(NUM_REGS)) begin
      rd_err = 1'b1;
    end else if (rd_idx == HOLD_IDX_W'(CTRL_IDX)) begin
      rd_val = ctrl_q;
    end else if (rd_idx == HOLD_IDX_W'(STATUS_IDX)) begin
      rd_val = status_i;
    end else begin
      for (int i = 2; i < NUM_REGS; i++) begin
        if (rd_idx == HOLD_IDX_W'(i)) rd_val = cfg_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      unique case (rd_state_q)
        RD_IDLE: begin
          arready_q <= 1'b1;
          if (s_axil.arvalid && arready_q) begin
            rd_state_q <= RD_RESP;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_val;
            rresp_q    <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        RD_RESP: begin
          if (s_axil.rready) begin
            rd_state_q <= RD_IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign s_axil.awready = aw_rdy;
  assign s_axil.wready  = w_rdy;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  assign ctrl_o  = ctrl_q;
  assign start_o = start_q;

  for (genvar g = 2; g < NUM_REGS; g++) begin : g_regs
    assign regs_o[(g-2)*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
  end

endmodule
